dispatch_router: RTL and testbench

DISPATCH_ROUTER -- requirements
Module: dispatch_router

---
 rtl/dispatch_router.sv | 167 ++++++++++++++++
 tb/tb_dispatch_router.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_router.sv
// Dispatch router: classifies decoded instructions into ALU/MEM/BR, buffers them
// in an in-order circular FIFO and hands the head to the matching issue queue.
module dispatch_router #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [2:0]  ALUOp,
  input  logic [6:0]  Opcode,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic        fu_mem,
  input  logic        fu_alu,
  input  logic        fu_br,
  output logic        alu_valid,
  input  logic        alu_ready,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        br_valid,
  input  logic        br_ready,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [2:0]  out_ALUOp,
  output logic [6:0]  out_Opcode,
  output logic [2:0]  out_func3,
  output logic [6:0]  out_func7,
  output logic [7:0]  illegal_cnt,
  output logic [15:0] dispatch_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    CLS_ALU = 2'd0,
    CLS_MEM = 2'd1,
    CLS_BR  = 2'd2
  } uop_class_e;

  typedef struct packed {
    uop_class_e  cls;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  alu_op;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
  } entry_t;

  entry_t        fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  uop_class_e in_cls;
  entry_t     in_entry;
  entry_t     head;
  logic       legal;
  logic       accept;
  logic       push;
  logic       drop;
  logic       pop;
  logic       not_empty;

  // Loads and branches also carry fu_alu=1, so MEM and BR must win over ALU.
  always_comb begin
    in_cls = CLS_ALU;
    if (fu_mem) begin
      in_cls = CLS_MEM;
    end else if (fu_br) begin
      in_cls = CLS_BR;
    end
  end

  assign legal     = fu_mem | fu_br | fu_alu;
  assign not_empty = (count != '0);
  assign in_ready  = reset_n && (count < CNT_FULL) && !flush;
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal;
  assign drop      = accept && !legal;

  assign in_entry = '{cls: in_cls, rs1: rs1, rs2: rs2, rd: rd, alu_op: ALUOp,
                      opcode: Opcode, func3: func3, func7: func7};

  assign head = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_entry;
    end
  end

  always_comb begin
    alu_valid  = 1'b0;
    mem_valid  = 1'b0;
    br_valid   = 1'b0;
    out_rs1    = '0;
    out_rs2    = '0;
    out_rd     = '0;
    out_ALUOp  = '0;
    out_Opcode = '0;
    out_func3  = '0;
    out_func7  = '0;
    if (reset_n && not_empty) begin
      out_rs1    = head.rs1;
      out_rs2    = head.rs2;
      out_rd     = head.rd;
      out_ALUOp  = head.alu_op;
      out_Opcode = head.opcode;
      out_func3  = head.func3;
      out_func7  = head.func7;
      if (!flush) begin
        case (head.cls)
          CLS_ALU: alu_valid = 1'b1;
          CLS_MEM: mem_valid = 1'b1;
          CLS_BR:  br_valid  = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Only the head may leave; a stalled head blocks every younger entry.
  assign pop = (alu_valid && alu_ready) || (mem_valid && mem_ready) ||
               (br_valid && br_ready);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      illegal_cnt  <= '0;
      dispatch_cnt <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr       <= rd_ptr + PTR_ONE;
        dispatch_cnt <= dispatch_cnt + 16'd1;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
      if (drop && (illegal_cnt != 8'hFF)) begin
        illegal_cnt <= illegal_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_dispatch_router.sv
// Self-checking bench for dispatch_router: a reference queue model tracks every
// accepted instruction and is compared against the DUT head on each cycle.
module tb_dispatch_router;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic [2:0]  ALUOp = '0;
  logic [6:0]  Opcode = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic        fu_mem = 1'b0, fu_alu = 1'b0, fu_br = 1'b0;
  logic        alu_valid, mem_valid, br_valid;
  logic        alu_ready = 1'b0, mem_ready = 1'b0, br_ready = 1'b0;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [2:0]  out_ALUOp;
  logic [6:0]  out_Opcode;
  logic [2:0]  out_func3;
  logic [6:0]  out_func7;
  logic [7:0]  illegal_cnt;
  logic [15:0] dispatch_cnt;

  int          check_count = 0;
  int          pass_count = 0;
  logic [36:0] exp_q [$];
  logic [7:0]  exp_ill = '0;
  logic [15:0] exp_disp = '0;
  bit          stim_done = 1'b0;

  always #5 clk = ~clk;

  dispatch_router #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .ALUOp(ALUOp), .Opcode(Opcode),
    .func3(func3), .func7(func7),
    .fu_mem(fu_mem), .fu_alu(fu_alu), .fu_br(fu_br),
    .alu_valid(alu_valid), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .br_valid(br_valid), .br_ready(br_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_ALUOp(out_ALUOp), .out_Opcode(out_Opcode),
    .out_func3(out_func3), .out_func7(out_func7),
    .illegal_cnt(illegal_cnt), .dispatch_cnt(dispatch_cnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds one instruction on the input until it is accepted; returns just after that edge.
  task automatic applyStimulus(input logic [2:0] fu, input logic [4:0] rd_v,
                               input logic [4:0] rs1_v, input logic [4:0] rs2_v,
                               input logic [2:0] aluop_v, input logic [6:0] opc_v);
    bit accepted;
    accepted = 1'b0;
    {fu_mem, fu_br, fu_alu} = fu;
    rd = rd_v;
    rs1 = rs1_v;
    rs2 = rs2_v;
    ALUOp = aluop_v;
    Opcode = opc_v;
    func3 = 3'($urandom);
    func7 = 7'($urandom);
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      accepted = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("push_timeout", 64'(accepted), 64'(1));
  endtask

  task automatic pushRand(input logic [2:0] fu);
    applyStimulus(fu, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom));
  endtask

  task automatic drain();
    {alu_ready, mem_ready, br_ready} = 3'b111;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) idle(1);
    checkOutput("drain", 64'(exp_q.size()), 64'(0));
  endtask

  // Reference model and scoreboard, evaluated mid-cycle before the next edge.
  always @(negedge clk) begin
    logic [2:0]  vld;
    logic [2:0]  exp_vld;
    logic [2:0]  rdy;
    logic [34:0] pay;
    logic        exp_in_ready;
    logic [1:0]  cls;
    vld = {br_valid, mem_valid, alu_valid};
    rdy = {br_ready, mem_ready, alu_ready};
    pay = {out_rs1, out_rs2, out_rd, out_ALUOp, out_Opcode, out_func3, out_func7};
    if (!reset_n) begin
      checkOutput("rst_in_ready", 64'(in_ready), 64'(0));
      checkOutput("rst_valids", 64'(vld), 64'(0));
      checkOutput("rst_payload", 64'(pay), 64'(0));
      exp_q.delete();
      exp_ill = '0;
      exp_disp = '0;
    end else begin
      exp_in_ready = (exp_q.size() < DEPTH) && !flush;
      checkOutput("in_ready", 64'(in_ready), 64'(exp_in_ready));
      checkOutput("dispatch_cnt", 64'(dispatch_cnt), 64'(exp_disp));
      checkOutput("illegal_cnt", 64'(illegal_cnt), 64'(exp_ill));
      if (flush) begin
        checkOutput("flush_valids", 64'(vld), 64'(0));
        exp_q.delete();
      end else if (exp_q.size() == 0) begin
        checkOutput("empty_valids", 64'(vld), 64'(0));
        checkOutput("empty_payload", 64'(pay), 64'(0));
      end else begin
        case (exp_q[0][36:35])
          2'd0:    exp_vld = 3'b001;
          2'd1:    exp_vld = 3'b010;
          default: exp_vld = 3'b100;
        endcase
        checkOutput("head_valid", 64'(vld), 64'(exp_vld));
        checkOutput("head_payload", 64'(pay), 64'(exp_q[0][34:0]));
        if ((exp_vld & rdy) != 3'b000) begin
          void'(exp_q.pop_front());
          exp_disp = exp_disp + 16'd1;
        end
      end
      if (exp_in_ready && in_valid) begin
        if (fu_mem) cls = 2'd1;
        else if (fu_br) cls = 2'd2;
        else cls = 2'd0;
        if (fu_mem || fu_br || fu_alu) begin
          exp_q.push_back({cls, rs1, rs2, rd, ALUOp, Opcode, func3, func7});
        end else if (exp_ill != 8'hFF) begin
          exp_ill = exp_ill + 8'd1;
        end
      end
    end
  end

  initial begin
    idle(3);
    reset_n = 1'b1;

    // Single ALU op with 1-cycle latency.
    alu_ready = 1'b1;
    applyStimulus(3'b001, 5'd1, 5'd2, 5'd0, 3'b011, 7'b0010011);
    @(negedge clk);
    checkOutput("alu_latency_valid", 64'(alu_valid), 64'(1));
    checkOutput("alu_latency_rd", 64'(out_rd), 64'(1));
    checkOutput("alu_latency_rs1", 64'(out_rs1), 64'(2));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("alu_disp_cnt", 64'(dispatch_cnt), 64'(1));
    checkOutput("alu_empty", 64'(alu_valid), 64'(0));
    @(posedge clk); #1;

    // Stalled load blocks a younger ALU op despite alu_ready.
    mem_ready = 1'b0;
    alu_ready = 1'b1;
    applyStimulus(3'b101, 5'd3, 5'd4, 5'd5, 3'b000, 7'b0000011);
    applyStimulus(3'b001, 5'd6, 5'd7, 5'd8, 3'b001, 7'b0110011);
    idle(10);
    @(negedge clk);
    checkOutput("stall_mem_valid", 64'(mem_valid), 64'(1));
    checkOutput("stall_alu_valid", 64'(alu_valid), 64'(0));
    @(posedge clk); #1;
    mem_ready = 1'b1;
    drain();
    checkOutput("stall_disp_cnt", 64'(exp_disp), 64'(3));

    // Full FIFO: no bypass of a slot freed in the same cycle.
    {alu_ready, mem_ready, br_ready} = 3'b000;
    pushRand(3'b011);
    pushRand(3'b001);
    pushRand(3'b101);
    pushRand(3'b001);
    @(negedge clk);
    checkOutput("full_in_ready", 64'(in_ready), 64'(0));
    checkOutput("full_head_br", 64'(br_valid), 64'(1));
    @(posedge clk); #1;
    fork
      pushRand(3'b001);
      begin
        idle(2);
        br_ready = 1'b1;
        idle(1);
        br_ready = 1'b0;
      end
    join
    drain();
    checkOutput("full_disp_cnt", 64'(dispatch_cnt), 64'(8));

    // Illegal instructions saturate the drop counter and never enqueue.
    for (int i = 0; i < 300; i++) pushRand(3'b000);
    @(negedge clk);
    checkOutput("illegal_sat", 64'(illegal_cnt), 64'(255));
    checkOutput("illegal_no_valid", 64'({br_valid, mem_valid, alu_valid}), 64'(0));
    @(posedge clk); #1;

    // Flush with three entries queued and a pending input.
    {alu_ready, mem_ready, br_ready} = 3'b000;
    pushRand(3'b001);
    pushRand(3'b100);
    pushRand(3'b010);
    {fu_mem, fu_br, fu_alu} = 3'b001;
    in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready", 64'(in_ready), 64'(0));
    checkOutput("flush_valid_bus", 64'({br_valid, mem_valid, alu_valid}), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    {alu_ready, mem_ready, br_ready} = 3'b111;
    @(negedge clk);
    checkOutput("post_flush_empty", 64'({br_valid, mem_valid, alu_valid}), 64'(0));
    checkOutput("flush_disp_cnt", 64'(dispatch_cnt), 64'(8));
    @(posedge clk); #1;

    // Nine ops across pointer wrap with random readies.
    stim_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 9; i++) pushRand(3'($urandom_range(7, 1)));
        stim_done = 1'b1;
      end
      begin
        while (!stim_done) begin
          {alu_ready, mem_ready, br_ready} = 3'($urandom);
          idle(1);
        end
      end
    join
    drain();
    checkOutput("wrap_disp_cnt", 64'(dispatch_cnt), 64'(17));

    // Reset mid-stream discards queued entries and clears counters.
    {alu_ready, mem_ready, br_ready} = 3'b000;
    pushRand(3'b001);
    pushRand(3'b101);
    pushRand(3'b000);
    in_valid = 1'b1;
    flush = 1'b1;
    reset_n = 1'b0;
    idle(2);
    reset_n = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    {alu_ready, mem_ready, br_ready} = 3'b111;
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(in_ready), 64'(1));
    checkOutput("reset_disp_cnt", 64'(dispatch_cnt), 64'(0));
    checkOutput("reset_ill_cnt", 64'(illegal_cnt), 64'(0));
    checkOutput("reset_valids", 64'({br_valid, mem_valid, alu_valid}), 64'(0));
    @(posedge clk); #1;
    idle(3);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
